// File: rtl/prbs_lfsr_gen_if.sv
// rtl/prbs_lfsr_gen_if.sv - control and serial-output handshake bundle for prbs_lfsr_gen
// The master side issues load/seed/burst_len and out_ready; the slave is the generator.
interface prbs_lfsr_gen_if #(
  parameter int WIDTH = 7,
  parameter int CNT_W = 16
);
  logic             load;
  logic [WIDTH-1:0] seed;
  logic [CNT_W-1:0] burst_len;
  logic             out_bit;
  logic             out_valid;
  logic             out_ready;
  logic             done;
  logic             seed_fixed;
  logic [WIDTH-1:0] lfsr_state;

  modport master (
    output load, seed, burst_len, out_ready,
    input  out_bit, out_valid, done, seed_fixed, lfsr_state
  );

  modport slave (
    input  load, seed, burst_len, out_ready,
    output out_bit, out_valid, done, seed_fixed, lfsr_state
  );
endinterface

// File: rtl/prbs_lfsr_gen.sv
// rtl/prbs_lfsr_gen.sv - parametrised Fibonacci LFSR PRBS source with burst control and valid/ready output
// A load starts (or restarts) a burst; each accepted bit steps the register once.
module prbs_lfsr_gen #(
  parameter int               WIDTH        = 7,
  parameter logic [WIDTH-1:0] TAPS         = 7'h41,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = 7'h01,
  parameter int               CNT_W        = 16
) (
  input  logic               clk,
  input  logic               reset,
  prbs_lfsr_gen_if.slave     bus
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fsm_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  fsm_t             r_fsm;
  logic [WIDTH-1:0] r_state;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_burst;
  logic             r_valid;
  logic             r_done;
  logic             r_seed_fixed;

  logic             w_fb;
  logic [WIDTH-1:0] w_next;
  logic             w_xfer;
  logic             w_seed_zero;
  logic             w_last;

  assign w_fb        = ^(r_state & TAPS);
  assign w_next      = {r_state[WIDTH-2:0], w_fb};
  assign w_xfer      = r_valid & bus.out_ready;
  assign w_seed_zero = (bus.seed == '0);
  // A zero burst register means continuous mode, so the last-bit test never fires there.
  assign w_last      = (r_burst != '0) && (r_count == (r_burst - CNT_ONE));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fsm        <= ST_IDLE;
      r_state      <= DEFAULT_SEED;
      r_count      <= '0;
      r_burst      <= '0;
      r_valid      <= 1'b0;
      r_done       <= 1'b0;
      r_seed_fixed <= 1'b0;
    end else begin
      r_done       <= 1'b0;
      r_seed_fixed <= 1'b0;
      if (bus.load) begin
        // Load wins over a coincident transfer: the register takes the seed, not the step.
        r_state      <= w_seed_zero ? DEFAULT_SEED : bus.seed;
        r_seed_fixed <= w_seed_zero;
        r_burst      <= bus.burst_len;
        r_count      <= '0;
        r_fsm        <= ST_RUN;
        r_valid      <= 1'b1;
      end else begin
        case (r_fsm)
          ST_RUN: begin
            if (w_xfer) begin
              r_state <= w_next;
              r_count <= r_count + CNT_ONE;
              if (w_last) begin
                r_fsm   <= ST_IDLE;
                r_valid <= 1'b0;
                r_done  <= 1'b1;
              end
            end
          end
          default: begin
            r_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.out_bit    = r_state[WIDTH-1];
  assign bus.out_valid  = r_valid;
  assign bus.done       = r_done;
  assign bus.seed_fixed = r_seed_fixed;
  assign bus.lfsr_state = r_state;

endmodule

// File: tb/tb_prbs_lfsr_gen.sv
// tb/tb_prbs_lfsr_gen.sv - scoreboard bench for prbs_lfsr_gen
// Stimulus pushes expected bits; a negedge monitor pops and compares on every presented bit.
module tb_prbs_lfsr_gen;
  localparam int W = 7;
  localparam int C = 16;
  localparam logic [W-1:0] TAPS = 7'h41;

  typedef struct packed {
    logic         b;
    logic [W-1:0] st;
    logic         last;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  exp_t q[$];

  logic m_valid = 1'b0;
  logic exp_done = 1'b0;
  logic exp_sf = 1'b0;

  prbs_lfsr_gen_if #(.WIDTH(W), .CNT_W(C)) bus ();

  prbs_lfsr_gen #(.WIDTH(W), .TAPS(TAPS), .DEFAULT_SEED(7'h01), .CNT_W(C)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Next state from the feedback rule: shift left, insert parity of the tapped bits.
  function automatic logic [W-1:0] ref_step(input logic [W-1:0] s);
    int p;
    logic [W:0] t;
    p = $countones(s & TAPS);
    t = {s, 1'b0} | (W+1)'(p % 2);
    return t[W-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [W-1:0] s, input int len);
    logic [W-1:0] st;
    int n;
    bus.load = 1'b1;
    bus.seed = s;
    bus.burst_len = C'(len);
    q.delete();
    st = (s == '0) ? 7'h01 : s;
    n = (len == 0) ? 300 : len;
    for (int i = 0; i < n; i++) begin
      q.push_back('{b: st[W-1], st: st, last: (len != 0) && (i == n - 1)});
      st = ref_step(st);
    end
    tick();
    bus.load = 1'b0;
  endtask

  task automatic run_until_idle(input int mode, input string name);
    bit finished;
    finished = 0;
    for (int c = 0; c < 400 && !finished; c++) begin
      case (mode)
        0: bus.out_ready = 1'b1;
        1: bus.out_ready = (c % 3 == 0);
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
      tick();
      if (!bus.out_valid) finished = 1;
    end
    checks++;
    if (!finished) begin
      errors++;
      $display("FAIL %s timeout actual=busy expected=idle", name);
    end
    bus.out_ready = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      m_valid  = 1'b0;
      exp_done = 1'b0;
      exp_sf   = 1'b0;
    end else begin
      chk("mon_out_valid", 32'(bus.out_valid), 32'(m_valid));
      chk("mon_done", 32'(bus.done), 32'(exp_done));
      chk("mon_seed_fixed", 32'(bus.seed_fixed), 32'(exp_sf));
      exp_done = 1'b0;
      exp_sf   = 1'b0;
      if (bus.load) begin
        m_valid = 1'b1;
        exp_sf  = (bus.seed == '0);
      end else if (m_valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL mon_underflow actual=bit_presented expected=no_bits_left");
        end else begin
          e = q[0];
          chk("mon_out_bit", 32'(bus.out_bit), 32'(e.b));
          chk("mon_lfsr_state", 32'(bus.lfsr_state), 32'(e.st));
          if (bus.out_ready) begin
            void'(q.pop_front());
            if (e.last) begin
              m_valid  = 1'b0;
              exp_done = 1'b1;
            end
          end
        end
      end
    end
  end

  initial begin
    logic [W-1:0] tbl [8];
    int vcnt, dcnt, len;
    logic [W-1:0] s;
    tbl = '{7'h01, 7'h03, 7'h07, 7'h0F, 7'h1F, 7'h3F, 7'h7F, 7'h7E};
    bus.load = 1'b0;
    bus.seed = '0;
    bus.burst_len = '0;
    bus.out_ready = 1'b0;
    #12;
    chk("rst_state", 32'(bus.lfsr_state), 32'h01);
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_seed_fixed", 32'(bus.seed_fixed), 0);
    chk("rst_out_bit", 32'(bus.out_bit), 0);
    tick();
    reset = 1'b0;
    tick();

    // continuous run from seed 01, full period
    bus.out_ready = 1'b1;
    do_load(7'h01, 0);
    for (int i = 0; i < 8; i++) begin
      chk("s1_state", 32'(bus.lfsr_state), 32'(tbl[i]));
      chk("s1_bit", 32'(bus.out_bit), 32'(tbl[i][W-1]));
      tick();
    end
    repeat (119) tick();
    chk("s1_period", 32'(bus.lfsr_state), 32'h01);

    // finite burst of 62
    do_load(7'h55, 62);
    vcnt = 0;
    dcnt = 0;
    for (int i = 0; i < 90; i++) begin
      if (bus.out_valid) vcnt++;
      if (bus.done) dcnt++;
      tick();
    end
    chk("s2_valid_cycles", 32'(vcnt), 62);
    chk("s2_done_pulses", 32'(dcnt), 1);

    // backpressure
    do_load(7'h01, 10);
    run_until_idle(1, "s3_idle");
    chk("s3_bits_left", 32'(q.size()), 0);

    // zero seed replacement, then non-zero seed
    do_load(7'h00, 0);
    chk("s4_state", 32'(bus.lfsr_state), 32'h01);
    chk("s4_seed_fixed", 32'(bus.seed_fixed), 1);
    repeat (10) tick();
    do_load(7'h2A, 0);
    chk("s4_nz_seed_fixed", 32'(bus.seed_fixed), 0);
    repeat (5) tick();

    // restart mid-burst, then asynchronous reset mid-burst
    do_load(7'h13, 20);
    repeat (5) tick();
    do_load(7'h7F, 20);
    chk("s5_reload_state", 32'(bus.lfsr_state), 32'h7F);
    run_until_idle(0, "s5_idle");
    chk("s5_bits_left", 32'(q.size()), 0);
    do_load(7'h44, 20);
    repeat (3) tick();
    #2;
    reset = 1'b1;
    q.delete();
    #1;
    chk("s5_rst_valid", 32'(bus.out_valid), 0);
    chk("s5_rst_state", 32'(bus.lfsr_state), 32'h01);
    chk("s5_rst_done", 32'(bus.done), 0);
    tick();
    reset = 1'b0;
    tick();

    // load coincident with a transfer
    bus.out_ready = 1'b1;
    do_load(7'h21, 4);
    repeat (2) tick();
    do_load(7'h5A, 4);
    chk("s6_state", 32'(bus.lfsr_state), 32'h5A);
    repeat (3) tick();
    chk("s6_no_early_done", 32'(bus.done), 0);
    tick();
    chk("s6_done", 32'(bus.done), 1);
    tick();

    // randomized bursts with random backpressure
    for (int it = 0; it < 20; it++) begin
      s = W'($urandom_range(0, 127));
      if (it % 5 == 0) s = '0;
      len = $urandom_range(0, 30);
      bus.out_ready = 1'($urandom_range(0, 1));
      do_load(s, len);
      if (len == 0) begin
        for (int c = 0; c < 40; c++) begin
          bus.out_ready = 1'($urandom_range(0, 1));
          tick();
        end
      end else begin
        run_until_idle(2, "rnd_idle");
        chk("rnd_bits_left", 32'(q.size()), 0);
      end
    end
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
